// File: rtl/cic_dec_sched.sv
// Sequencer for a time-shared CIC decimator: derives the sample strobe, per-channel
// integrator slots and the comb strobe, and hides the filter's warm-up outputs.
module cic_dec_sched #(
  parameter int SYS_CLK_FREQ = 6400000,
  parameter int MIXING_FREQ  = 320000,
  parameter int SAMPLE_RATE  = 800,
  parameter int NCH          = 2,
  parameter int WARMUP       = 2,
  parameter int CHW          = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  output logic           busy,
  output logic           clr,
  output logic           samp_en,
  output logic           ch_en,
  output logic [CHW-1:0] ch_sel,
  output logic           dec_stb,
  output logic           out_valid,
  output logic [15:0]    dec_idx
);

  localparam int SAMPLE_DIV = SYS_CLK_FREQ / MIXING_FREQ;
  localparam int DEC        = MIXING_FREQ / SAMPLE_RATE;
  localparam int PW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW         = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int WW         = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(DEC - 1);
  localparam logic [PW-1:0] NCH_P      = PW'(NCH);
  localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP - 1);

  if (SAMPLE_DIV < NCH + 1) begin : g_bad_div
    $fatal(1, "cic_dec_sched: SAMPLE_DIV must be at least NCH+1");
  end
  if (DEC < 1) begin : g_bad_dec
    $fatal(1, "cic_dec_sched: DEC must be at least 1");
  end
  if ((SYS_CLK_FREQ % MIXING_FREQ) != 0 || (MIXING_FREQ % SAMPLE_RATE) != 0) begin : g_bad_ratio
    $fatal(1, "cic_dec_sched: frequency ratios must be integers");
  end
  if ((1 << CHW) < NCH) begin : g_bad_chw
    $fatal(1, "cic_dec_sched: CHW too narrow for NCH");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARMUP, S_RUN, S_STOPPING} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg;
  logic [SW-1:0] samp_reg;
  logic [WW-1:0] warm_reg;
  logic [15:0]   dec_idx_reg;
  logic          active, phase_last;

  assign active     = (state_reg == S_WARMUP) || (state_reg == S_RUN) || (state_reg == S_STOPPING);
  assign phase_last = (phase_reg == PHASE_LAST);
  assign dec_idx    = dec_idx_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != S_IDLE);
    clr        = (state_reg == S_CLEAR);
    samp_en    = active && phase_last;
    ch_en      = active && (phase_reg < NCH_P);
    ch_sel     = ch_en ? CHW'(phase_reg) : '0;
    dec_stb    = active && phase_last && (samp_reg == SAMP_LAST);
    out_valid  = dec_stb && ((state_reg == S_RUN) || (state_reg == S_STOPPING));
    case (state_reg)
      S_IDLE:     if (start && !stop) state_next = S_CLEAR;
      S_CLEAR:    state_next = (WARMUP == 0) ? S_RUN : S_WARMUP;
      // An abort during warm-up takes precedence over the strobe that would finish it.
      S_WARMUP: begin
        if (stop)                                 state_next = S_IDLE;
        else if (dec_stb && warm_reg == WARM_LAST) state_next = S_RUN;
      end
      S_RUN:      if (stop) state_next = S_STOPPING;
      S_STOPPING: if (dec_stb) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg   <= '0;
      samp_reg    <= '0;
      warm_reg    <= '0;
      dec_idx_reg <= '0;
    end else begin
      if (active && state_next != S_IDLE) begin
        phase_reg <= phase_last ? '0 : phase_reg + 1'b1;
        if (phase_last) samp_reg <= (samp_reg == SAMP_LAST) ? '0 : samp_reg + 1'b1;
        if (state_reg == S_WARMUP && dec_stb) warm_reg <= warm_reg + 1'b1;
      end else begin
        phase_reg <= '0;
        samp_reg  <= '0;
        warm_reg  <= '0;
      end
      if (state_reg == S_CLEAR) dec_idx_reg <= '0;
      else if (out_valid)       dec_idx_reg <= dec_idx_reg + 1'b1;
    end
  end

endmodule
